fp_align_pipe: RTL and testbench

- Parametrised, pipelined mantissa-alignment stage for the FP adder, ahead of the mantissa adder and normaliser.
- Takes two unpacked operands (sign, biased exponent, fraction), restores the hidden bit, treats denormals, picks the larger-magnitude operand and its sign as the result sign, right-shifts the smaller with guard/round/sticky, and two's-complements it on effective subtraction.
- Two-stage pipeline with valid/ready backpressure.

---
 rtl/fp_align_pipe.sv | 194 +++++++++++++++++++
 tb/tb_fp_align_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// ============================================================================
// Module      : fp_align_pipe
// Description : Two-stage FP adder mantissa alignment (hidden bit, swap,
//               right shift with G/R/S, negate on effective subtraction).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_a,
  input  logic                 sign_b,
  input  logic [EXP_W-1:0]     exp_a,
  input  logic [EXP_W-1:0]     exp_b,
  input  logic [MAN_W-1:0]     frac_a,
  input  logic [MAN_W-1:0]     frac_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 res_sign,
  output logic [EXP_W-1:0]     res_exp,
  output logic                 eff_sub,
  output logic                 special,
  output logic [MAN_W+5:0]     man_big,
  output logic [MAN_W+5:0]     man_small
);

  localparam int          AW   = MAN_W + 6;
  localparam int          FW   = MAN_W + 1;
  localparam int          SW   = MAN_W + 3;
  localparam logic [31:0] SW_U = 32'(SW);

  // Handshake
  logic s1_ready, s2_ready;
  logic v1_q, v1_d, v2_q, v2_d;
  logic ld1, ld2;

  assign s2_ready = ~v2_q | out_ready;
  assign s1_ready = ~v1_q | s2_ready;
  assign in_ready = s1_ready;
  assign ld1      = in_valid & s1_ready;
  assign ld2      = v1_q & s2_ready;
  assign v1_d     = s1_ready ? in_valid : v1_q;
  assign v2_d     = s2_ready ? v1_q : v2_q;

  // Stage 1: unpack, compare, swap
  logic                 hid_a, hid_b;
  logic [EXP_W-1:0]     eexp_a, eexp_b;
  logic [EXP_W+FW-1:0]  key_a, key_b;
  logic                 a_big, tie, sub_w;

  assign hid_a  = |exp_a;
  assign hid_b  = |exp_b;
  assign eexp_a = hid_a ? exp_a : EXP_W'(1);
  assign eexp_b = hid_b ? exp_b : EXP_W'(1);
  assign key_a  = {eexp_a, hid_a, frac_a};
  assign key_b  = {eexp_b, hid_b, frac_b};
  assign a_big  = key_a >= key_b;
  assign tie    = key_a == key_b;
  assign sub_w  = sign_a ^ sign_b;

  logic [EXP_W-1:0] s1_diff_q, s1_diff_d;
  logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_sub_q,  s1_sub_d;
  logic             s1_spec_q, s1_spec_d;
  logic [FW-1:0]    s1_mbig_q, s1_mbig_d;
  logic [FW-1:0]    s1_msml_q, s1_msml_d;

  always_comb begin
    s1_diff_d = s1_diff_q;
    s1_exp_d  = s1_exp_q;
    s1_sign_d = s1_sign_q;
    s1_sub_d  = s1_sub_q;
    s1_spec_d = s1_spec_q;
    s1_mbig_d = s1_mbig_q;
    s1_msml_d = s1_msml_q;
    if (ld1) begin
      s1_sub_d  = sub_w;
      s1_spec_d = (&exp_a) | (&exp_b);
      // Equal magnitudes of opposite sign must cancel to +0
      s1_sign_d = (tie & sub_w) ? 1'b0 : (a_big ? sign_a : sign_b);
      if (a_big) begin
        s1_diff_d = eexp_a - eexp_b;
        s1_exp_d  = eexp_a;
        s1_mbig_d = {hid_a, frac_a};
        s1_msml_d = {hid_b, frac_b};
      end else begin
        s1_diff_d = eexp_b - eexp_a;
        s1_exp_d  = eexp_b;
        s1_mbig_d = {hid_b, frac_b};
        s1_msml_d = {hid_a, frac_a};
      end
    end
  end

  // Stage 2: shift the smaller mantissa; bits below R collapse into S
  logic [SW-1:0]   shift_in;
  logic [2*SW-1:0] shift_wide;
  logic [SW-1:0]   shifted;
  logic            sticky;
  logic [AW-1:0]   sml_pos;

  assign shift_in   = {s1_msml_q, 2'b00};
  assign shift_wide = {shift_in, {SW{1'b0}}} >> s1_diff_q;

  always_comb begin
    if (32'(s1_diff_q) >= SW_U) begin
      shifted = '0;
      sticky  = |s1_msml_q;
    end else begin
      shifted = shift_wide[2*SW-1:SW];
      sticky  = |shift_wide[SW-1:0];
    end
  end

  assign sml_pos = {2'b00, shifted, sticky};

  logic             o_sign_q, o_sign_d;
  logic [EXP_W-1:0] o_exp_q,  o_exp_d;
  logic             o_sub_q,  o_sub_d;
  logic             o_spec_q, o_spec_d;
  logic [AW-1:0]    o_big_q,  o_big_d;
  logic [AW-1:0]    o_sml_q,  o_sml_d;

  always_comb begin
    o_sign_d = o_sign_q;
    o_exp_d  = o_exp_q;
    o_sub_d  = o_sub_q;
    o_spec_d = o_spec_q;
    o_big_d  = o_big_q;
    o_sml_d  = o_sml_q;
    if (ld2) begin
      o_sign_d = s1_sign_q;
      o_exp_d  = s1_exp_q;
      o_sub_d  = s1_sub_q;
      o_spec_d = s1_spec_q;
      o_big_d  = {2'b00, s1_mbig_q, 3'b000};
      o_sml_d  = s1_sub_q ? (~sml_pos + AW'(1)) : sml_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_diff_q <= '0;
      s1_exp_q  <= '0;
      s1_sign_q <= 1'b0;
      s1_sub_q  <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_mbig_q <= '0;
      s1_msml_q <= '0;
      o_sign_q  <= 1'b0;
      o_exp_q   <= '0;
      o_sub_q   <= 1'b0;
      o_spec_q  <= 1'b0;
      o_big_q   <= '0;
      o_sml_q   <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      s1_diff_q <= s1_diff_d;
      s1_exp_q  <= s1_exp_d;
      s1_sign_q <= s1_sign_d;
      s1_sub_q  <= s1_sub_d;
      s1_spec_q <= s1_spec_d;
      s1_mbig_q <= s1_mbig_d;
      s1_msml_q <= s1_msml_d;
      o_sign_q  <= o_sign_d;
      o_exp_q   <= o_exp_d;
      o_sub_q   <= o_sub_d;
      o_spec_q  <= o_spec_d;
      o_big_q   <= o_big_d;
      o_sml_q   <= o_sml_d;
    end
  end

  assign out_valid = v2_q;
  assign res_sign  = o_sign_q;
  assign res_exp   = o_exp_q;
  assign eff_sub   = o_sub_q;
  assign special   = o_spec_q;
  assign man_big   = o_big_q;
  assign man_small = o_sml_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_align_pipe.sv
// ============================================================================
// Module      : tb_fp_align_pipe
// Description : Table-driven scoreboard bench for fp_align_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fp_align_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int AW    = MAN_W + 6;
  localparam int NV    = 14;

  typedef struct {
    logic             sa;
    logic [EXP_W-1:0] ea;
    logic [MAN_W-1:0] fa;
    logic             sb;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] fb;
    logic             rs;
    logic [EXP_W-1:0] re;
    logic             sub;
    logic             sp;
    logic [AW-1:0]    big;
    logic [AW-1:0]    sml;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             out_valid;
  logic             out_ready;
  logic             res_sign;
  logic [EXP_W-1:0] res_exp;
  logic             eff_sub;
  logic             special;
  logic [AW-1:0]    man_big;
  logic [AW-1:0]    man_small;

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .frac_a    (frac_a),
    .frac_b    (frac_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_sign  (res_sign),
    .res_exp   (res_exp),
    .eff_sub   (eff_sub),
    .special   (special),
    .man_big   (man_big),
    .man_small (man_small)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_push = 0;
  int   first_out = -1;
  int   last_out = -1;
  vec_t sb_q[$];
  vec_t tbl[NV];
  vec_t mon_e;

  logic [EXP_W-1:0] hold_exp;
  logic [AW-1:0]    hold_big, hold_sml;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sa, input logic [EXP_W-1:0] ea, input logic [MAN_W-1:0] fa,
                              input logic sb, input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] fb,
                              input logic rs, input logic [EXP_W-1:0] re, input logic sub, input logic sp,
                              input logic [AW-1:0] big, input logic [AW-1:0] sml);
    vec_t v;
    v.sa = sa; v.ea = ea; v.fa = fa; v.sb = sb; v.eb = eb; v.fb = fb;
    v.rs = rs; v.re = re; v.sub = sub; v.sp = sp; v.big = big; v.sml = sml;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    sign_a = v.sa; exp_a = v.ea; frac_a = v.fa;
    sign_b = v.sb; exp_b = v.eb; frac_b = v.fb;
  endtask

  // Present one pair; the expectation is queued on the cycle it is accepted
  task automatic send(input vec_t v);
    int n = 0;
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end else begin
      sb_q.push_back(v);
      n_push++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(sb_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got res_exp=0x%0h man_big=0x%0h, expected no output", res_exp, man_big);
      end else begin
        mon_e = sb_q.pop_front();
        chk("res_sign",  64'(res_sign),  64'(mon_e.rs));
        chk("res_exp",   64'(res_exp),   64'(mon_e.re));
        chk("eff_sub",   64'(eff_sub),   64'(mon_e.sub));
        chk("special",   64'(special),   64'(mon_e.sp));
        chk("man_big",   64'(man_big),   64'(mon_e.big));
        chk("man_small", 64'(man_small), 64'(mon_e.sml));
      end
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
  end

  initial begin
    tbl[0]  = mk(0, 127, 23'h0,      0, 127, 23'h0,      0, 127, 0, 0, 29'h04000000, 29'h04000000);
    tbl[1]  = mk(0, 127, 23'h0,      1, 126, 23'h0,      0, 127, 1, 0, 29'h04000000, 29'h1E000000);
    tbl[2]  = mk(1, 126, 23'h0,      0, 127, 23'h0,      0, 127, 1, 0, 29'h04000000, 29'h1E000000);
    tbl[3]  = mk(1, 128, 23'h0,      0, 127, 23'h0,      1, 128, 1, 0, 29'h04000000, 29'h1E000000);
    tbl[4]  = mk(0, 127, 23'h0,      0,  97, 23'h0,      0, 127, 0, 0, 29'h04000000, 29'h00000001);
    tbl[5]  = mk(0,   0, 23'h2,      0,   0, 23'h1,      0,   1, 0, 0, 29'h00000010, 29'h00000008);
    tbl[6]  = mk(1, 127, 23'h400000, 0, 127, 23'h400000, 0, 127, 1, 0, 29'h06000000, 29'h1A000000);
    tbl[7]  = mk(0, 255, 23'h0,      0, 127, 23'h0,      0, 255, 0, 1, 29'h04000000, 29'h00000001);
    tbl[8]  = mk(0, 127, 23'h0,      0, 123, 23'h7,      0, 127, 0, 0, 29'h04000000, 29'h00400003);
    tbl[9]  = mk(0, 127, 23'h0,      1, 123, 23'h7,      0, 127, 1, 0, 29'h04000000, 29'h1FBFFFFD);
    tbl[10] = mk(0, 127, 23'h0,      0, 102, 23'h7FFFFF, 0, 127, 0, 0, 29'h04000000, 29'h00000003);
    tbl[11] = mk(0, 127, 23'h0,      0, 101, 23'h0,      0, 127, 0, 0, 29'h04000000, 29'h00000001);
    tbl[12] = mk(0, 127, 23'h0,      1,   0, 23'h0,      0, 127, 1, 0, 29'h04000000, 29'h00000000);
    tbl[13] = mk(0, 127, 23'h0,      0, 125, 23'h7,      0, 127, 0, 0, 29'h04000000, 29'h0100000E);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(tbl[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_man_big",   64'(man_big),   64'd0);
    chk("rst_man_small", 64'(man_small), 64'd0);
    chk("rst_res_exp",   64'(res_exp),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Two-cycle latency for a single pair
    @(posedge clk); #1;
    drive(tbl[0]);
    in_valid = 1'b1;
    sb_q.push_back(tbl[0]);
    @(negedge clk);
    chk("lat_in_ready", 64'(in_ready),  64'd1);
    chk("lat_c0",       64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_c2", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("lat_c3", 64'(out_valid), 64'd0);

    // Back-to-back stream of the remaining table
    n_out = 0; first_out = -1;
    @(posedge clk); #1;
    for (int i = 1; i < NV; i++) send(tbl[i]);
    wait_empty("stream_drain");
    chk("stream_count",     64'(n_out), 64'(NV - 1));
    chk("stream_no_bubble", 64'(last_out - first_out + 1), 64'(NV - 1));

    // Backpressure: only two pairs fit while the output is blocked
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_push = 0;
    fork
      begin
        send(tbl[1]);
        send(tbl[4]);
        send(tbl[5]);
        send(tbl[6]);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepted",  64'(n_push),    64'd2);
        chk("bp_in_ready",  64'(in_ready),  64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        hold_exp = res_exp; hold_big = man_big; hold_sml = man_small;
        repeat (3) @(negedge clk);
        chk("bp_hold_exp", 64'(res_exp),   64'(hold_exp));
        chk("bp_hold_big", 64'(man_big),   64'(hold_big));
        chk("bp_hold_sml", 64'(man_small), 64'(hold_sml));
        chk("bp_hold_sml_val", 64'(man_small), 64'h1E000000);
        n_out = 0; first_out = -1;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_empty("bp_drain");
    chk("bp_count",     64'(n_out), 64'd4);
    chk("bp_no_bubble", 64'(last_out - first_out + 1), 64'd4);

    // Reset with both stages full discards everything in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(tbl[7]);
    send(tbl[8]);
    @(negedge clk);
    chk("mid_full", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_res_sign",  64'(res_sign),  64'd0);
    chk("mid_res_exp",   64'(res_exp),   64'd0);
    chk("mid_eff_sub",   64'(eff_sub),   64'd0);
    chk("mid_special",   64'(special),   64'd0);
    chk("mid_man_big",   64'(man_big),   64'd0);
    chk("mid_man_small", 64'(man_small), 64'd0);
    chk("mid_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    n_out = 0;
    repeat (5) @(negedge clk);
    chk("mid_no_stale", 64'(n_out), 64'd0);

    // Pipe still works after the mid-flight reset
    @(posedge clk); #1;
    send(tbl[3]);
    wait_empty("post_rst_drain");
    chk("post_rst_count", 64'(n_out), 64'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
